// File: rtl/mplier_pkg.sv
// Shared constants and FSM state type for the multiplier scheduler.
package mplier_pkg;

  localparam int N_REQ = 4;  // requesters sharing the multiplier
  localparam int OP_W  = 3;  // operand width
  localparam int RES_W = 6;  // product width (7*7 = 49 fits)
  localparam int ID_W  = 2;  // requester index width
  localparam int CNT_W = 3;  // latency counter width, covers MEM_LAT up to 7

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter: combinational one-hot grant searched from ptr
// upward, pointer advanced past the winner only when a transfer happens.
module rr_arbiter
  import mplier_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             xfer
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] idx;
  logic            found;

  // First valid requester at or after ptr wins; nothing is granted while
  // disabled or held in reset.
  always_comb begin
    grant    = '0;
    grant_id = ptr_q;
    found    = 1'b0;
    idx      = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr_q + k[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
    if (rst || !en) begin
      grant = '0;
    end
  end

  assign xfer = |grant;

  // Pointer moves to the requester after the winner, wrapping mod 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mplier_sched.sv
// Shares one fixed-latency times-table multiplier between four requesters:
// one operation in flight, round-robin grant, tagged single-cycle response.
module mplier_sched
  import mplier_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*OP_W-1:0]  req_a,
  input  logic [N_REQ*OP_W-1:0]  req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   busy,
  output logic [OP_W-1:0]        mem_a,
  output logic [OP_W-1:0]        mem_b,
  output logic                   mem_read,
  input  logic [RES_W-1:0]       mem_result
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [OP_W-1:0]  mem_a_q, mem_b_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [RES_W-1:0] rsp_result_q;

  logic             arb_en;
  logic             xfer;
  logic [ID_W-1:0]  grant_id;
  logic             wait_done;

  logic [OP_W-1:0]  a_arr [N_REQ];
  logic [OP_W-1:0]  b_arr [N_REQ];

  // Unpack the per-requester operand fields.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*OP_W +: OP_W];
    assign b_arr[gi] = req_b[gi*OP_W +: OP_W];
  end

  rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req_valid (req_valid),
    .grant     (req_ready),
    .grant_id  (grant_id),
    .xfer      (xfer)
  );

  // Counter reaches 1 in the last WAIT cycle; <= guards against a zero load.
  assign wait_done = (cnt_q <= CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    arb_en    = (state_q == IDLE);
    mem_read  = (state_q == ISSUE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Operand latch on grant, latency countdown, and product capture on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a_q      <= '0;
      mem_b_q      <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      if (xfer) begin
        mem_a_q <= a_arr[grant_id];
        mem_b_q <= b_arr[grant_id];
        id_q    <= grant_id;
      end
      if (state_q == ISSUE) begin
        cnt_q <= LAT_INIT;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
        if (wait_done) begin
          rsp_result_q <= mem_result;
          rsp_id_q     <= id_q;
        end
      end
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_b      = mem_b_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_mplier_sched.sv
// Bench for mplier_sched: times-table multiplier model with fixed latency,
// cycle-count reference model of the scheduler, directed tables and random run.
module tb_mplier_sched;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_result;
  logic        busy;
  logic [2:0]  mem_a, mem_b;
  logic        mem_read;
  logic [5:0]  mem_result;

  always #5 clk = ~clk;

  mplier_sched #(.MEM_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy), .mem_a(mem_a), .mem_b(mem_b),
    .mem_read(mem_read), .mem_result(mem_result)
  );

  // Multiplier: product valid L edges after the read is sampled, 63 otherwise.
  logic [L-1:0] st_v;
  logic [5:0]   st_p [L];
  always @(posedge clk) begin
    st_v[0] <= mem_read;
    st_p[0] <= mem_a * mem_b;
    for (int k = 1; k < L; k++) begin
      st_v[k] <= st_v[k-1];
      st_p[k] <= st_p[k-1];
    end
  end
  assign mem_result = (st_v[L-1] === 1'b1) ? st_p[L-1] : 6'd63;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: operation timing expressed as absolute cycle numbers.
  int cyc = 0;
  int next_free = 0;
  int ptr_m = 0;
  int rd_cyc = -100, rsp_cyc = -100;
  int exp_a, exp_b, exp_id, exp_res;
  int hs_cyc = -100;
  bit prev_rst = 1'b1;
  bit auto_drop = 1'b1;

  typedef struct { int id; int res; int lat; } rsp_t;
  rsp_t rsp_log[$];
  int   gnt_log[$];
  int   hs_log[$];

  // Check the current cycle against the model, then advance one clock.
  task automatic tick();
    logic [3:0] exp_rdy;
    logic [3:0] drop;
    int w;
    rsp_t r;
    #1;
    exp_rdy = '0;
    drop = '0;
    w = -1;
    if (!rst && cyc >= next_free) begin
      for (int k = 0; k < 4; k++)
        if (w < 0 && req_valid[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("mem_read", mem_read, cyc == rd_cyc);
    if (cyc >= rd_cyc && cyc <= rd_cyc + L) begin
      chk("mem_a", mem_a, exp_a);
      chk("mem_b", mem_b, exp_b);
    end
    chk("rsp_valid", rsp_valid, cyc == rsp_cyc);
    if (cyc == rsp_cyc) begin
      chk("rsp_id", rsp_id, exp_id);
      chk("rsp_result", rsp_result, exp_res);
      r.id = rsp_id; r.res = rsp_result; r.lat = cyc - hs_cyc;
      rsp_log.push_back(r);
      $display("RSP cycle=%0d id=%0d result=%0d latency=%0d", cyc, r.id, r.res, r.lat);
    end
    chk("busy", busy, cyc < next_free);
    if (prev_rst) begin
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_b", mem_b, 0);
    end
    if (rst) begin
      next_free = cyc + 1; rd_cyc = -100; rsp_cyc = -100; ptr_m = 0;
    end else if (w >= 0) begin
      exp_a   = req_a[3*w +: 3];
      exp_b   = req_b[3*w +: 3];
      exp_id  = w;
      exp_res = exp_a * exp_b;
      rd_cyc = cyc + 1; rsp_cyc = cyc + 2 + L; next_free = cyc + 3 + L;
      ptr_m = (w + 1) % 4;
      hs_cyc = cyc;
      gnt_log.push_back(w);
      hs_log.push_back(cyc);
      if (auto_drop) drop[w] = 1'b1;
    end
    prev_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    req_valid = req_valid & ~drop;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[3*i +: 3] = 3'(a);
    req_b[3*i +: 3] = 3'(b);
    req_valid[i] = 1'b1;
  endtask

  // Run until the response log reaches n entries or the budget runs out.
  task automatic run_until_rsp(input int n, input int budget);
    int t;
    t = 0;
    while (rsp_log.size() < n && t < budget) begin
      tick();
      t++;
    end
    if (rsp_log.size() < n) chk("rsp_timeout", rsp_log.size(), n);
  endtask

  typedef struct { int id; int a; int b; int res; } vec_t;
  vec_t vecs [6];

  initial begin
    int n0, g0, start;
    vecs[0] = '{2, 3, 7, 21};
    vecs[1] = '{0, 0, 5, 0};
    vecs[2] = '{3, 7, 1, 7};
    vecs[3] = '{1, 7, 7, 49};
    vecs[4] = '{1, 5, 6, 30};
    vecs[5] = '{0, 4, 4, 16};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;

    // Reset held with random requests: no grant, all outputs zero.
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'($urandom);
      tick();
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
    tick();

    // Single-requester table: immediate grant, fixed latency, exact product.
    for (int v = 0; v < 6; v++) begin
      n0 = rsp_log.size();
      start = cyc;
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      run_until_rsp(n0 + 1, 20);
      if (rsp_log.size() > n0) begin
        chk("tbl_grant_delay", hs_cyc - start, 0);
        chk("tbl_id", rsp_log[n0].id, vecs[v].id);
        chk("tbl_result", rsp_log[n0].res, vecs[v].res);
        chk("tbl_latency", rsp_log[n0].lat, L + 2);
      end
    end

    // All four valid right after reset: order 0..3, spaced L+3 cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    n0 = rsp_log.size();
    g0 = gnt_log.size();
    set_req(0, 1, 2); set_req(1, 2, 3); set_req(2, 4, 5); set_req(3, 7, 7);
    run_until_rsp(n0 + 4, 60);
    if (rsp_log.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("all4_grant", gnt_log[g0 + i], i);
        chk("all4_id", rsp_log[n0 + i].id, i);
      end
      chk("all4_res0", rsp_log[n0 + 0].res, 2);
      chk("all4_res1", rsp_log[n0 + 1].res, 6);
      chk("all4_res2", rsp_log[n0 + 2].res, 20);
      chk("all4_res3", rsp_log[n0 + 3].res, 49);
      for (int i = 1; i < 4; i++)
        chk("all4_spacing", hs_log[g0 + i] - hs_log[g0 + i - 1], L + 3);
    end
    tick();

    // Fairness: 0 and 3 held valid continuously alternate.
    auto_drop = 1'b0;
    g0 = gnt_log.size();
    set_req(0, 6, 2); set_req(3, 3, 3);
    for (int t = 0; t < 60 && gnt_log.size() < g0 + 4; t++) tick();
    req_valid = '0;
    auto_drop = 1'b1;
    if (gnt_log.size() >= g0 + 4) begin
      chk("fair_0", gnt_log[g0 + 0], 0);
      chk("fair_1", gnt_log[g0 + 1], 3);
      chk("fair_2", gnt_log[g0 + 2], 0);
      chk("fair_3", gnt_log[g0 + 3], 3);
    end else chk("fair_timeout", gnt_log.size(), g0 + 4);
    for (int t = 0; t < L + 4; t++) tick();

    // Reset in the first WAIT cycle aborts silently.
    g0 = gnt_log.size();
    set_req(2, 5, 5);
    for (int t = 0; t < 10 && gnt_log.size() == g0; t++) tick();
    tick();                 // ISSUE cycle
    rst = 1'b1; tick(); rst = 1'b0;
    n0 = rsp_log.size();
    for (int t = 0; t < 10; t++) tick();
    chk("abort_no_rsp", rsp_log.size(), n0);
    start = cyc;
    set_req(1, 6, 7);
    run_until_rsp(n0 + 1, 20);
    if (rsp_log.size() > n0) begin
      chk("post_rst_grant_delay", hs_cyc - start, 0);
      chk("post_rst_id", rsp_log[n0].id, 1);
      chk("post_rst_result", rsp_log[n0].res, 42);
      chk("post_rst_latency", rsp_log[n0].lat, L + 2);
    end

    // Random traffic against the model.
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, int'($urandom_range(7)), int'($urandom_range(7)));
      tick();
    end
    req_valid = '0;
    for (int t = 0; t < L + 4; t++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
